crypt_block_feeder: RTL and testbench



---
 rtl/crypt_feeder_pkg.sv | 24 ++
 rtl/crypt_feeder_timer.sv | 35 +++
 rtl/crypt_block_feeder.sv | 176 +++++++++++++++++
 tb/tb_crypt_block_feeder.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_feeder_pkg.sv
// Shared types, default sizes and the block byte-indexing helper for the
// byte-serial crypto feeder.
package crypt_feeder_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      UNLOAD = 2'd3
   } feeder_state_t;

   localparam int DEF_BYTE_W      = 8;
   localparam int DEF_BLOCK_BYTES = 16;
   localparam int DEF_KEY_W       = 10;
   localparam int DEF_TIMEOUT     = 255;

   // LSB position of byte idx inside a flat block whose byte 0 sits in the MSBs.
   function automatic int byte_slice(input int idx,
                                     input int nbytes = DEF_BLOCK_BYTES,
                                     input int bw     = DEF_BYTE_W);
      return (nbytes - 1 - idx) * bw;
   endfunction

endpackage

// File: rtl/crypt_feeder_timer.sv
// Down-counter guarding the wait for the core's done strobe. load arms it
// with TIMEOUT, en counts one cycle down, expired is high once it hits zero.
module crypt_feeder_timer
   import crypt_feeder_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int            TW  = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TOP = TW'(TIMEOUT);

   logic [TW-1:0] count;

   // Arm on load, otherwise count down and park at zero.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= TOP;
      end else if (en && (count != '0)) begin
         count <= count - TW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/crypt_block_feeder.sv
// Byte-serial front end for the cryptographic core: gathers one block from a
// valid/ready byte stream, starts the core, waits (bounded) for its result and
// streams the result back out one byte per cycle.
module crypt_block_feeder
   import crypt_feeder_pkg::*;
#(
   parameter int BYTE_W      = DEF_BYTE_W,
   parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
   parameter int KEY_W       = DEF_KEY_W,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          mode,
   input  logic [KEY_W-1:0]              key,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BYTE_W-1:0]             in_data,
   input  logic                          in_last,
   output logic                          core_start,
   output logic                          core_mode,
   output logic [KEY_W-1:0]              core_key,
   output logic [BLOCK_BYTES*BYTE_W-1:0] core_din,
   input  logic                          core_done,
   input  logic [BLOCK_BYTES*BYTE_W-1:0] core_dout,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BYTE_W-1:0]             out_data,
   output logic                          out_last,
   output logic                          busy,
   output logic                          err_short,
   output logic                          err_long,
   output logic                          err_timeout
);

   localparam int            BLK_W    = BLOCK_BYTES * BYTE_W;
   localparam int            CW       = $clog2(BLOCK_BYTES);
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

   feeder_state_t    state, state_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [BLK_W-1:0] in_buf;   // block being assembled; drives core_din
   logic [BLK_W-1:0] res_buf;  // core result being streamed out
   logic [KEY_W-1:0] key_q;
   logic             mode_q;

   logic in_fire, out_fire;
   logic load_byte, cap_cfg, cap_res;
   logic tmr_load, tmr_en, tmr_expired;

   assign in_ready   = (state == LOAD);
   assign core_start = (state == START);
   assign out_valid  = (state == UNLOAD);
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;

   assign busy       = (state != LOAD) || (cnt != '0);
   assign out_last   = out_valid && (cnt == LAST_IDX);
   assign out_data   = res_buf[byte_slice(int'(cnt), BLOCK_BYTES, BYTE_W) +: BYTE_W];

   assign core_din   = in_buf;
   assign core_key   = key_q;
   assign core_mode  = mode_q;

   crypt_feeder_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // State register and shared byte counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state, counter and datapath-strobe decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_d     = state;
      cnt_d       = cnt;
      load_byte   = 1'b0;
      cap_cfg     = 1'b0;
      cap_res     = 1'b0;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
      err_short   = 1'b0;
      err_long    = 1'b0;
      err_timeout = 1'b0;

      case (state)
         LOAD: begin
            if (in_fire) begin
               load_byte = 1'b1;
               cap_cfg   = (cnt == '0);
               if (cnt == LAST_IDX) begin
                  cnt_d = '0;
                  if (in_last) state_d  = START;
                  else         err_long = 1'b1;
               end else if (in_last) begin
                  cnt_d     = '0;
                  err_short = 1'b1;
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end

         START: begin
            tmr_load = 1'b1;
            state_d  = WAIT;
         end

         WAIT: begin
            // done wins even in the cycle the timer runs out
            if (core_done) begin
               cap_res = 1'b1;
               cnt_d   = '0;
               state_d = UNLOAD;
            end else if (tmr_expired) begin
               err_timeout = 1'b1;
               state_d     = LOAD;
            end else begin
               tmr_en = 1'b1;
            end
         end

         UNLOAD: begin
            if (out_fire) begin
               if (cnt == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = LOAD;
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // Block buffers plus key/mode latched alongside byte 0.
   // NOTE: the buffers are plain registers, not a RAM, so they take the reset
   // like any other flop and read back as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_buf  <= '0;
         res_buf <= '0;
         key_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         if (load_byte) begin
            in_buf[byte_slice(int'(cnt), BLOCK_BYTES, BYTE_W) +: BYTE_W] <= in_data;
         end
         if (cap_cfg) begin
            key_q  <= key;
            mode_q <= mode;
         end
         if (cap_res) begin
            res_buf <= core_dout;
         end
      end
   end

endmodule

// File: tb/tb_crypt_block_feeder.sv
// Directed bench for crypt_block_feeder with a small core model that returns
// the block XOR all-ones five cycles after core_start.
module tb_crypt_block_feeder;

   localparam int BYTE_W      = 8;
   localparam int BLOCK_BYTES = 16;
   localparam int KEY_W       = 10;
   localparam int TIMEOUT     = 8;
   localparam int BLK_W       = BLOCK_BYTES * BYTE_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              mode = 1'b0;
   logic [KEY_W-1:0]  key = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BYTE_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              core_start;
   logic              core_mode;
   logic [KEY_W-1:0]  core_key;
   logic [BLK_W-1:0]  core_din;
   logic              core_done;
   logic [BLK_W-1:0]  core_dout;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [BYTE_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              err_short;
   logic              err_long;
   logic              err_timeout;

   int tests = 0;
   int fails = 0;

   crypt_block_feeder #(
      .BYTE_W      (BYTE_W),
      .BLOCK_BYTES (BLOCK_BYTES),
      .KEY_W       (KEY_W),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode        (mode),
      .key         (key),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .core_start  (core_start),
      .core_mode   (core_mode),
      .core_key    (core_key),
      .core_din    (core_din),
      .core_done   (core_done),
      .core_dout   (core_dout),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .err_short   (err_short),
      .err_long    (err_long),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Core model: answers with core_din ^ '1 five cycles after a start, when enabled.
   logic             core_en = 1'b1;
   logic             manual_done = 1'b0;
   logic             model_done;
   logic [BLK_W-1:0] model_res;
   int               model_dly;

   assign core_done = model_done | manual_done;
   assign core_dout = model_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_done <= 1'b0;
         model_dly  <= 0;
         model_res  <= '0;
      end else begin
         model_done <= 1'b0;
         if (core_start && core_en) begin
            model_dly <= 5;
            model_res <= core_din ^ {BLK_W{1'b1}};
         end else if (model_dly == 1) begin
            model_done <= 1'b1;
            model_dly  <= 0;
         end else if (model_dly > 1) begin
            model_dly <= model_dly - 1;
         end
      end
   end

   // Monitor: event counters, output capture and stall-hold tracking.
   logic [8:0] out_q[$];
   int         start_cnt = 0, short_cnt = 0, long_cnt = 0, to_cnt = 0;
   int         hold_viol = 0, cyc = 0, done_edge = -1, ov_edge = -1;
   logic       stall_prev = 1'b0, ov_prev = 1'b0;
   logic [8:0] held = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         if (core_start)  start_cnt++;
         if (err_short)   short_cnt++;
         if (err_long)    long_cnt++;
         if (err_timeout) to_cnt++;
         if (out_valid && out_ready) out_q.push_back({out_last, out_data});
         if (stall_prev && ({out_last, out_data} !== held)) hold_viol++;
         stall_prev = out_valid && !out_ready;
         held       = {out_last, out_data};
         if (core_done) done_edge = cyc;
         if (out_valid && !ov_prev) ov_edge = cyc;
         ov_prev = out_valid;
      end else begin
         stall_prev = 1'b0;
         ov_prev    = 1'b0;
      end
   end

   // Drive n bytes starting at value first; in_last on byte last_idx (-1 = never).
   // key/mode are only valid on byte 0 and scrambled afterwards.
   task automatic send_block(input logic [7:0] first, input int n, input int last_idx,
                             input logic [KEY_W-1:0] k, input logic m,
                             output int short_at, output int long_at);
      int budget;
      short_at = -1;
      long_at  = -1;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = first + 8'(i);
         in_last  = (i == last_idx);
         key      = (i == 0) ? k : ~k;
         mode     = (i == 0) ? m : ~m;
         budget   = 0;
         @(negedge clk);
         while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_ready byte %0d: in_ready=%b required 1", i, in_ready);
         end
         if (err_short) short_at = i;
         if (err_long)  long_at  = i;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      key      = '0;
      mode     = 1'b0;
   endtask

   // Run out_ready through a 4-cycle pattern until n bytes are captured.
   task automatic collect(input int n, input logic [3:0] pat);
      int i;
      i = 0;
      while (out_q.size() < n && i < 400) begin
         out_ready = pat[i % 4];
         @(posedge clk); #1;
         i++;
      end
      out_ready = 1'b1;
      tests++;
      if (out_q.size() < n) begin
         fails++;
         $display("FAIL collect_timeout: got %0d bytes required %0d", out_q.size(), n);
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Compare the captured stream with base, base-1, ... and out_last on byte 15.
   task automatic check_stream(input logic [7:0] base, input string name);
      logic [8:0] got, exp;
      tests++;
      if (out_q.size() != BLOCK_BYTES) begin
         fails++;
         $display("FAIL %s_count: got %0d bytes required %0d", name, out_q.size(), BLOCK_BYTES);
      end
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 9'bx;
         exp = {1'(i == BLOCK_BYTES - 1), base - 8'(i)};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL %s_byte%0d: got last=%b data=%h required last=%b data=%h",
                     name, i, got[8], got[7:0], exp[8], exp[7:0]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({in_ready, out_valid, core_start, busy, out_last, err_short, err_long, err_timeout}
          !== 8'b1000_0000) begin
         fails++;
         $display("FAIL reset_flags: got ir/ov/cs/busy/ol/es/el/et=%b required 10000000",
                  {in_ready, out_valid, core_start, busy, out_last, err_short, err_long, err_timeout});
      end
      tests++;
      if ({core_mode, core_key, core_din, out_data} !== '0) begin
         fails++;
         $display("FAIL reset_data: got mode=%b key=%h din=%h out=%h required all zero",
                  core_mode, core_key, core_din, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: got in_ready=%b busy=%b required 1 0", in_ready, busy);
      end
   endtask

   task automatic test_encrypt();
      int sa, la, s0;
      out_q.delete();
      s0 = start_cnt;
      send_block(8'h00, 16, 15, 10'h2A5, 1'b0, sa, la);
      tests++;
      if (core_start !== 1'b1) begin
         fails++;
         $display("FAIL enc_start_latency: core_start=%b required 1 one cycle after last byte", core_start);
      end
      tests++;
      if (sa != -1 || la != -1) begin
         fails++;
         $display("FAIL enc_no_err: short_at=%0d long_at=%0d required -1 -1", sa, la);
      end
      collect(16, 4'b1111);
      tests++;
      if (start_cnt - s0 != 1) begin
         fails++;
         $display("FAIL enc_start_count: got %0d pulses required 1", start_cnt - s0);
      end
      tests++;
      if (core_din !== 128'h000102030405060708090A0B0C0D0E0F) begin
         fails++;
         $display("FAIL enc_din: got %h required 000102030405060708090a0b0c0d0e0f", core_din);
      end
      tests++;
      if (core_key !== 10'h2A5 || core_mode !== 1'b0) begin
         fails++;
         $display("FAIL enc_cfg: got key=%h mode=%b required 2a5 0", core_key, core_mode);
      end
      tests++;
      if (ov_edge - done_edge != 1) begin
         fails++;
         $display("FAIL enc_done_latency: got %0d cycles required 1", ov_edge - done_edge);
      end
      check_stream(8'hFF, "enc");
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL enc_idle: got in_ready=%b busy=%b required 1 0", in_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      int sa, la, s0;
      out_q.delete();
      hold_viol = 0;
      s0 = start_cnt;
      send_block(8'h00, 16, 15, 10'h2A5, 1'b0, sa, la);
      collect(16, 4'b1001);
      tests++;
      if (hold_viol != 0) begin
         fails++;
         $display("FAIL bp_hold: got %0d changes during stalls required 0", hold_viol);
      end
      tests++;
      if (start_cnt - s0 != 1) begin
         fails++;
         $display("FAIL bp_start_count: got %0d required 1", start_cnt - s0);
      end
      check_stream(8'hFF, "bp");
   endtask

   task automatic test_short();
      int sa, la, s0, e0;
      s0 = start_cnt;
      e0 = short_cnt;
      send_block(8'h40, 5, 4, 10'h111, 1'b1, sa, la);
      repeat (10) @(posedge clk);
      #1;
      tests++;
      if (sa != 4 || la != -1) begin
         fails++;
         $display("FAIL short_where: short_at=%0d long_at=%0d required 4 -1", sa, la);
      end
      tests++;
      if (short_cnt - e0 != 1) begin
         fails++;
         $display("FAIL short_pulse: got %0d cycles high required 1", short_cnt - e0);
      end
      tests++;
      if (start_cnt != s0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL short_nostart: starts=%0d in_ready=%b busy=%b required 0 1 0",
                  start_cnt - s0, in_ready, busy);
      end
      out_q.delete();
      send_block(8'h10, 16, 15, 10'h3C3, 1'b1, sa, la);
      collect(16, 4'b1111);
      tests++;
      if (start_cnt - s0 != 1 || core_key !== 10'h3C3 || core_mode !== 1'b1) begin
         fails++;
         $display("FAIL short_recover: starts=%0d key=%h mode=%b required 1 3c3 1",
                  start_cnt - s0, core_key, core_mode);
      end
      check_stream(8'hEF, "short_next");
   endtask

   task automatic test_long();
      int sa, la, s0, e0;
      s0 = start_cnt;
      e0 = long_cnt;
      send_block(8'h60, 16, -1, 10'h0F0, 1'b0, sa, la);
      repeat (10) @(posedge clk);
      #1;
      tests++;
      if (la != 15 || sa != -1) begin
         fails++;
         $display("FAIL long_where: long_at=%0d short_at=%0d required 15 -1", la, sa);
      end
      tests++;
      if (long_cnt - e0 != 1) begin
         fails++;
         $display("FAIL long_pulse: got %0d cycles high required 1", long_cnt - e0);
      end
      tests++;
      if (start_cnt != s0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL long_nostart: starts=%0d in_ready=%b busy=%b required 0 1 0",
                  start_cnt - s0, in_ready, busy);
      end
   endtask

   task automatic test_timeout();
      int sa, la, s0, t0, n;
      core_en = 1'b0;
      s0 = start_cnt;
      t0 = to_cnt;
      send_block(8'h00, 16, 15, 10'h0AA, 1'b0, sa, la);
      // now in START; the next cycle is the first WAIT cycle
      @(posedge clk); #1;
      n = 0;
      while (!err_timeout && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n != TIMEOUT) begin
         fails++;
         $display("FAIL timeout_latency: pulse %0d cycles after WAIT entry required %0d", n, TIMEOUT);
      end
      @(posedge clk); #1;
      tests++;
      if (err_timeout !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL timeout_after: err_timeout=%b in_ready=%b required 0 1", err_timeout, in_ready);
      end
      tests++;
      if (to_cnt - t0 != 1) begin
         fails++;
         $display("FAIL timeout_pulse: got %0d cycles high required 1", to_cnt - t0);
      end
      manual_done = 1'b1;
      @(posedge clk); #1;
      manual_done = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || start_cnt - s0 != 1) begin
         fails++;
         $display("FAIL timeout_late_done: out_valid=%b busy=%b in_ready=%b starts=%0d required 0 0 1 1",
                  out_valid, busy, in_ready, start_cnt - s0);
      end
      core_en = 1'b1;
   endtask

   task automatic test_reset_mid_unload();
      int sa, la, budget;
      out_q.delete();
      send_block(8'h00, 16, 15, 10'h2A5, 1'b0, sa, la);
      out_ready = 1'b1;
      budget = 0;
      while (out_q.size() < 3 && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      tests++;
      if (out_q.size() < 3) begin
         fails++;
         $display("FAIL rst_unload_reach: got %0d bytes required 3", out_q.size());
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || core_start !== 1'b0) begin
         fails++;
         $display("FAIL rst_unload_async: out_valid=%b busy=%b in_ready=%b core_start=%b required 0 0 1 0",
                  out_valid, busy, in_ready, core_start);
      end
      tests++;
      if (core_key !== '0 || core_mode !== 1'b0) begin
         fails++;
         $display("FAIL rst_unload_cfg: key=%h mode=%b required 0 0", core_key, core_mode);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_unload_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      out_q.delete();
      send_block(8'h20, 16, 15, 10'h155, 1'b1, sa, la);
      tests++;
      if (core_key !== 10'h155 || core_mode !== 1'b1 ||
          core_din !== 128'h202122232425262728292A2B2C2D2E2F) begin
         fails++;
         $display("FAIL rst_next_block: key=%h mode=%b din=%h required 155 1 202122232425262728292a2b2c2d2e2f",
                  core_key, core_mode, core_din);
      end
      collect(16, 4'b1111);
      check_stream(8'hDF, "rst_next");
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_backpressure();
      test_short();
      test_long();
      test_timeout();
      test_reset_mid_unload();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
